// File: rtl/beat_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : beat_sequencer
// Description : Musical time base. Counts clock cycles into semiquavers
//               (SEMI_CYCLES each) and semiquavers into crotchets (4 each),
//               stepping through NUM_CROTCHETS crotchets once (LOOP=0) or
//               repeatedly (LOOP=1) under start/stop control. Each pulse is
//               asserted in the same cycle as the index value it announces.
// Ports       : clk            - system clock
//               rst_n          - synchronous active-low reset
//               start          - level; (re)starts from crotchet 0
//               stop           - level; returns to idle (wins over start)
//               vsync_pulse    - frame strobe (frame-sync build only)
//               crotchet       - current crotchet index
//               crotchet_pulse - one-cycle strobe on crotchet entry
//               semi           - semiquaver index within the crotchet
//               semi_pulse     - one-cycle strobe on semiquaver entry
//               phrase         - crotchet[6:3]
//               playing        - high while playing
//               done           - high after a non-looping run completes
// Options     : define BEAT_SEQUENCER_FRAME_SYNC_EN to hold every crotchet
//               boundary until the next vsync_pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module beat_sequencer #(
  parameter int SEMI_CYCLES   = 5460000,
  parameter int NUM_CROTCHETS = 104,
  parameter int LOOP          = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
`ifdef BEAT_SEQUENCER_FRAME_SYNC_EN
  input  logic       vsync_pulse,
`endif
  output logic [6:0] crotchet,
  output logic       crotchet_pulse,
  output logic [1:0] semi,
  output logic       semi_pulse,
  output logic [3:0] phrase,
  output logic       playing,
  output logic       done
);

  localparam int             TW            = $clog2(SEMI_CYCLES);
  localparam logic [TW-1:0]  TIMER_LAST    = TW'(SEMI_CYCLES - 1);
  localparam logic [6:0]     LAST_CROTCHET = 7'(NUM_CROTCHETS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [TW-1:0]   timer, timer_nx;
  logic [6:0]      crotchet_nx;
  logic [1:0]      semi_nx;
  logic            crotchet_pulse_nx;
  logic            semi_pulse_nx;
  logic            boundary;   // last cycle of semiquaver 3
  logic            advance;    // crotchet advances on this edge
  logic            hold;       // waiting for a frame start
  logic            sync;       // frame start available this cycle

`ifdef BEAT_SEQUENCER_FRAME_SYNC_EN
  logic            pending, pending_nx;
  assign hold = pending;
  assign sync = vsync_pulse;
`else
  assign hold = 1'b0;
  assign sync = 1'b1;
`endif

  assign phrase   = crotchet[6:3];
  assign boundary = (timer == TIMER_LAST) && (semi == 2'd3);

  always_comb begin
    state_nx          = state;
    timer_nx          = timer;
    crotchet_nx       = crotchet;
    semi_nx           = semi;
    crotchet_pulse_nx = 1'b0;
    semi_pulse_nx     = 1'b0;
    advance           = 1'b0;

    if (stop) begin
      state_nx    = S_IDLE;
      timer_nx    = '0;
      crotchet_nx = '0;
      semi_nx     = '0;
    end else if (start) begin
      state_nx          = S_PLAY;
      timer_nx          = '0;
      crotchet_nx       = '0;
      semi_nx           = '0;
      crotchet_pulse_nx = 1'b1;
      semi_pulse_nx     = 1'b1;
    end else if (state == S_PLAY) begin
      if (hold) begin
        // Parked at semi 3 with the timer at zero until a frame starts.
        timer_nx = '0;
        advance  = sync;
      end else if (boundary) begin
        timer_nx = '0;
        advance  = sync;
      end else if (timer == TIMER_LAST) begin
        timer_nx      = '0;
        semi_nx       = semi + 2'd1;
        semi_pulse_nx = 1'b1;
      end else begin
        timer_nx = timer + 1'b1;
      end

      if (advance) begin
        timer_nx = '0;
        semi_nx  = '0;
        if ((crotchet == LAST_CROTCHET) && (LOOP == 0)) begin
          // Final crotchet index is held on display while done.
          state_nx = S_DONE;
        end else begin
          crotchet_nx       = (crotchet == LAST_CROTCHET) ? 7'd0 : crotchet + 7'd1;
          crotchet_pulse_nx = 1'b1;
          semi_pulse_nx     = 1'b1;
        end
      end
    end
  end

`ifdef BEAT_SEQUENCER_FRAME_SYNC_EN
  always_comb begin
    pending_nx = pending;
    if (stop || start || advance) begin
      pending_nx = 1'b0;
    end else if ((state == S_PLAY) && !pending && boundary) begin
      pending_nx = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending <= 1'b0;
    end else begin
      pending <= pending_nx;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      timer          <= '0;
      crotchet       <= '0;
      semi           <= '0;
      crotchet_pulse <= 1'b0;
      semi_pulse     <= 1'b0;
      playing        <= 1'b0;
      done           <= 1'b0;
    end else begin
      state          <= state_nx;
      timer          <= timer_nx;
      crotchet       <= crotchet_nx;
      semi           <= semi_nx;
      crotchet_pulse <= crotchet_pulse_nx;
      semi_pulse     <= semi_pulse_nx;
      playing        <= (state_nx == S_PLAY);
      done           <= (state_nx == S_DONE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_beat_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_beat_sequencer
// Description : Bench for beat_sequencer. Three instances share the control
//               inputs: u0 (S=3, N=5, looping), u1 (S=3, N=5, one-shot) and
//               u2 (S=2, N=104, looping). A position-in-crotchet model
//               predicts every output each cycle; directed literal checks
//               pin the model at the documented cycle numbers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_beat_sequencer;

`ifdef BEAT_SEQUENCER_FRAME_SYNC_EN
  localparam bit FS = 1'b1;
`else
  localparam bit FS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic vsync = 1'b0;

  logic [6:0] cr0, cr1, cr2;
  logic       cp0, cp1, cp2;
  logic [1:0] sm0, sm1, sm2;
  logic       sp0, sp1, sp2;
  logic [3:0] ph0, ph1, ph2;
  logic       pl0, pl1, pl2;
  logic       dn0, dn1, dn2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  beat_sequencer #(.SEMI_CYCLES(3), .NUM_CROTCHETS(5), .LOOP(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
`ifdef BEAT_SEQUENCER_FRAME_SYNC_EN
    .vsync_pulse(vsync),
`endif
    .crotchet(cr0), .crotchet_pulse(cp0), .semi(sm0), .semi_pulse(sp0),
    .phrase(ph0), .playing(pl0), .done(dn0));

  beat_sequencer #(.SEMI_CYCLES(3), .NUM_CROTCHETS(5), .LOOP(0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
`ifdef BEAT_SEQUENCER_FRAME_SYNC_EN
    .vsync_pulse(vsync),
`endif
    .crotchet(cr1), .crotchet_pulse(cp1), .semi(sm1), .semi_pulse(sp1),
    .phrase(ph1), .playing(pl1), .done(dn1));

  beat_sequencer #(.SEMI_CYCLES(2), .NUM_CROTCHETS(104), .LOOP(1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
`ifdef BEAT_SEQUENCER_FRAME_SYNC_EN
    .vsync_pulse(vsync),
`endif
    .crotchet(cr2), .crotchet_pulse(cp2), .semi(sm2), .semi_pulse(sp2),
    .phrase(ph2), .playing(pl2), .done(dn2));

  // Model: position counted in cycles from the start of the crotchet.
  int P_S[3] = '{3, 3, 2};
  int P_N[3] = '{5, 5, 104};
  int P_L[3] = '{1, 0, 1};
  int m_cr[3];
  int m_pos[3];
  bit m_pend[3];
  bit m_play[3];
  bit m_done[3];
  bit m_cp[3];
  bit m_sp[3];

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void model_step(int i, bit r, bit st, bit sp, bit vs);
    int q;
    bit adv;
    q = 4 * P_S[i];
    adv = 1'b0;
    m_cp[i] = 1'b0;
    m_sp[i] = 1'b0;
    if (!r || sp) begin
      m_play[i] = 0; m_done[i] = 0; m_cr[i] = 0; m_pos[i] = 0; m_pend[i] = 0;
    end else if (st) begin
      m_play[i] = 1; m_done[i] = 0; m_cr[i] = 0; m_pos[i] = 0; m_pend[i] = 0;
      m_cp[i] = 1; m_sp[i] = 1;
    end else if (m_play[i]) begin
      if (m_pend[i]) begin
        adv = vs;
      end else begin
        m_pos[i]++;
        if (m_pos[i] == q) begin
          if (FS && !vs) m_pend[i] = 1;
          else adv = 1'b1;
        end else if (m_pos[i] % P_S[i] == 0) begin
          m_sp[i] = 1;
        end
      end
      if (adv) begin
        m_pend[i] = 0;
        m_pos[i] = 0;
        if (m_cr[i] == P_N[i] - 1 && P_L[i] == 0) begin
          m_play[i] = 0;
          m_done[i] = 1;
        end else begin
          m_cr[i] = (m_cr[i] + 1) % P_N[i];
          m_cp[i] = 1;
          m_sp[i] = 1;
        end
      end
    end
  endfunction

  function automatic void cmp(int i, int cr, int sm, int cp, int sp, int ph, int pl, int dn);
    int q;
    int esm;
    q = 4 * P_S[i];
    esm = (m_pos[i] >= q) ? 3 : m_pos[i] / P_S[i];
    chk($sformatf("u%0d crotchet", i), cr, m_cr[i]);
    chk($sformatf("u%0d semi", i), sm, esm);
    chk($sformatf("u%0d crotchet_pulse", i), cp, int'(m_cp[i]));
    chk($sformatf("u%0d semi_pulse", i), sp, int'(m_sp[i]));
    chk($sformatf("u%0d phrase", i), ph, m_cr[i] / 8);
    chk($sformatf("u%0d playing", i), pl, int'(m_play[i]));
    chk($sformatf("u%0d done", i), dn, int'(m_done[i]));
  endfunction

  // Compare process: model advances on each edge from the sampled inputs.
  initial begin
    bit r, st, sp, vs;
    forever begin
      @(posedge clk);
      r = rst_n; st = start; sp = stop; vs = vsync;
      for (int i = 0; i < 3; i++) model_step(i, r, st, sp, vs);
      #1;
      cmp(0, cr0, sm0, cp0, sp0, ph0, pl0, dn0);
      cmp(1, cr1, sm1, cp1, sp1, ph1, pl1, dn1);
      cmp(2, cr2, sm2, cp2, sp2, ph2, pl2, dn2);
    end
  end

`ifdef BEAT_SEQUENCER_FRAME_SYNC_EN
  initial begin
    forever begin
      repeat (19) @(posedge clk);
      #2 vsync = 1'b1;
      @(posedge clk);
      #2 vsync = 1'b0;
    end
  end
`endif

  // Hand-computed values for the cycle-counted build.
  function automatic void lit(string nm, int act, int exp);
`ifndef BEAT_SEQUENCER_FRAME_SYNC_EN
    chk(nm, act, exp);
`endif
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset crotchet", cr0, 0);
    chk("reset playing", pl0, 0);
    chk("reset done", dn1, 0);
    chk("reset pulse", cp0, 0);

    // start during cycle 0
    #1 start = 1'b1;
    @(posedge clk); #1;
    lit("c1 crotchet_pulse", cp0, 1);
    lit("c1 semi_pulse", sp0, 1);
    lit("c1 playing", pl0, 1);
    #1 start = 1'b0;
    repeat (3) @(posedge clk); #1;
    lit("c4 semi", sm0, 1);
    lit("c4 semi_pulse", sp0, 1);
    repeat (9) @(posedge clk); #1;
    lit("c13 crotchet", cr0, 1);
    lit("c13 semi", sm0, 0);
    lit("c13 crotchet_pulse", cp0, 1);
    repeat (48) @(posedge clk); #1;
    lit("c61 loop crotchet", cr0, 0);
    lit("c61 loop pulse", cp0, 1);
    lit("c61 loop phrase", ph0, 0);
    lit("c61 oneshot done", dn1, 1);
    lit("c61 oneshot playing", pl1, 0);
    lit("c61 oneshot crotchet", cr1, 4);
    lit("c61 oneshot pulse", cp1, 0);
    #1 start = 1'b1;
    @(posedge clk); #1;
    lit("restart crotchet", cr1, 0);
    lit("restart pulse", cp1, 1);
    lit("restart done", dn1, 0);
    #1 start = 1'b0;

    // stop at crotchet 2 semi 1 (cycle 28 of this run)
    repeat (27) @(posedge clk); #1;
    lit("c28 crotchet", cr0, 2);
    lit("c28 semi", sm0, 1);
    #1 stop = 1'b1;
    @(posedge clk); #1;
    chk("stop playing", pl0, 0);
    chk("stop crotchet", cr0, 0);
    #1 stop = 1'b0;
    repeat (50) @(posedge clk);
    #2 start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    chk("start+stop playing", pl0, 0);
    #1 start = 1'b0; stop = 1'b0;

    // long sequence on u2: crotchet 96 at cycle 1+96*8
    @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk); #1;
    #1 start = 1'b0;
    repeat (768) @(posedge clk); #1;
    lit("u2 c96 crotchet", cr2, 96);
    lit("u2 c96 phrase", ph2, 12);
    lit("u2 c96 pulse", cp2, 1);
    repeat (100) @(posedge clk);

    // held start restarts every cycle
    #2 start = 1'b1;
    repeat (10) @(posedge clk);
    #2 start = 1'b0;

    // randomized control traffic
    repeat (4000) begin
      @(posedge clk);
      #2;
      start = ($urandom_range(0, 299) == 0);
      stop  = ($urandom_range(0, 399) == 0);
      rst_n = ($urandom_range(0, 999) != 0);
    end
    @(posedge clk);
    #2 start = 1'b0; stop = 1'b0; rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
